piston_position_ctrl: RTL and testbench

//  Parametrised piston-position controller for the ideal-gas display: drives the piston depth
//  `pos` (larger = more compressed) toward a mode-selected target at a programmable rate.

---
 rtl/piston_pkg.sv | 36 +++
 rtl/piston_target_calc.sv | 50 +++++
 rtl/piston_position_ctrl.sv | 145 ++++++++++++++
 tb/tb_piston_position_ctrl.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/piston_pkg.sv
// Shared types and helpers for the piston position controller.
// Mode 3 (GAS) behaviour is selected by the GAS_MODE_EN macro in piston_target_calc.
package piston_pkg;

  localparam int unsigned MolesW = 3;
  localparam int unsigned TempW  = 3;
  localparam int unsigned NtW    = 6;
  localparam int unsigned RawPad = 8;

  typedef enum logic [1:0] {
    MANUAL = 2'd0,
    MOLES  = 2'd1,
    TEMP   = 2'd2,
    GAS    = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MOVE = 2'd1,
    HOLD = 2'd2
  } state_e;

  // Payload presented to the target calculator each cycle.
  typedef struct packed {
    mode_e             mode;
    logic [MolesW-1:0] numMoles;
    logic [TempW-1:0]  temp;
  } target_req_t;

  function automatic int clampPos(input int v, input int lo, input int hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

endpackage

// File: rtl/piston_target_calc.sv
// Combinational raw-target computation and saturation for each mode.
// GAS_MODE_EN defined: mode 3 targets POS_MAX+1 - NT_STEP*n*T; otherwise mode 3 acts as a frozen manual mode.
module piston_target_calc
  import piston_pkg::*;
#(
  parameter int unsigned W         = 8,
  parameter int unsigned POS_MIN   = 1,
  parameter int unsigned POS_MAX   = 200,
  parameter int unsigned MOL_STEP  = 40,
  parameter int unsigned TEMP_BASE = 160,
  parameter int unsigned TEMP_STEP = 40,
  parameter int unsigned NT_STEP   = 10
) (
  input  target_req_t  req,
  output logic [W-1:0] clampTarget_c,
  output logic         manual_c,
  output logic         reqEn_c
);

  localparam int unsigned RawW = W + RawPad;

  logic signed [RawW-1:0] raw;
  logic [NtW-1:0]         ntProd;

  // Raw value is wide enough that subtraction never wraps; clamp brings it into range.
  always_comb begin
    raw      = '0;
    manual_c = 1'b0;
    reqEn_c  = 1'b0;
    ntProd   = NtW'(req.numMoles) * NtW'(req.temp);
    case (req.mode)
      MOLES: raw = RawW'(POS_MAX + 1) - RawW'(MOL_STEP) * RawW'(req.numMoles);
      TEMP:  raw = RawW'(TEMP_BASE + 1) - RawW'(TEMP_STEP) * RawW'(req.temp);
      GAS: begin
        raw = RawW'(POS_MAX + 1) - RawW'(NT_STEP) * RawW'(ntProd);
`ifdef GAS_MODE_EN
        manual_c = 1'b0;
`else
        manual_c = 1'b1;
`endif
      end
      default: begin
        manual_c = 1'b1;
        reqEn_c  = 1'b1;
      end
    endcase
    clampTarget_c = W'(clampPos(int'(raw), int'(POS_MIN), int'(POS_MAX)));
  end

endmodule

// File: rtl/piston_position_ctrl.sv
// Piston position controller: tick divider, target register, IDLE/MOVE/HOLD FSM and step datapath.
// Optional combined n*T mode is enabled with the GAS_MODE_EN macro (see piston_target_calc).
module piston_position_ctrl
  import piston_pkg::*;
#(
  parameter int unsigned W         = 8,
  parameter int unsigned POS_MIN   = 1,
  parameter int unsigned POS_MAX   = 200,
  parameter int unsigned MOL_STEP  = 40,
  parameter int unsigned TEMP_BASE = 160,
  parameter int unsigned TEMP_STEP = 40,
  parameter int unsigned NT_STEP   = 10,
  parameter int unsigned STEP      = 1,
  parameter int unsigned TICK_DIV  = 1
) (
  input  logic         clk,
  input  logic         clear,
  input  logic         enable,
  input  logic [1:0]   mode,
  input  logic         compress_in,
  input  logic         expand_in,
  input  logic [2:0]   num_moles,
  input  logic [2:0]   temp,
  output logic [W-1:0] pos,
  output logic [W-1:0] target,
  output logic         busy,
  output logic         settled,
  output logic         dir_compress
);

  localparam int unsigned CntW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [W-1:0] StepW   = W'(STEP);
  localparam logic [W:0]   StepX   = (W+1)'(STEP);
  localparam logic [W:0]   PosMinX = (W+1)'(POS_MIN);
  localparam logic [W:0]   PosMaxX = (W+1)'(POS_MAX);

  target_req_t    req;
  logic [W-1:0]   clampTarget;
  logic           manualMode;
  logic           reqEn;

  logic [CntW-1:0] tickCnt;
  logic            tick;

  state_e         state, stateNext;
  logic [W-1:0]   posNext, targetNext;
  logic           dirNext, settledNext, busyNext;
  logic [W:0]     upSum;

  assign req = '{mode: mode_e'(mode), numMoles: num_moles, temp: temp};

  piston_target_calc #(
    .W         (W),
    .POS_MIN   (POS_MIN),
    .POS_MAX   (POS_MAX),
    .MOL_STEP  (MOL_STEP),
    .TEMP_BASE (TEMP_BASE),
    .TEMP_STEP (TEMP_STEP),
    .NT_STEP   (NT_STEP)
  ) uCalc (
    .req           (req),
    .clampTarget_c (clampTarget),
    .manual_c      (manualMode),
    .reqEn_c       (reqEn)
  );

  // Motion tick divider; frozen along with everything else when disabled.
  assign tick = enable && (tickCnt == CntW'(TICK_DIV - 1));

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      tickCnt <= '0;
    end else if (enable) begin
      if (tick) tickCnt <= '0;
      else      tickCnt <= tickCnt + CntW'(1);
    end
  end

  // Next state, next position and status flags.
  always_comb begin
    stateNext   = state;
    posNext     = pos;
    targetNext  = target;
    dirNext     = dir_compress;
    settledNext = 1'b0;
    upSum       = {1'b0, pos} + StepX;

    if (enable) begin
      targetNext = manualMode ? pos : clampTarget;
      case (state)
        IDLE: begin
          if (!manualMode) begin
            stateNext = MOVE;
          end else if (tick && reqEn) begin
            if (compress_in && !expand_in)
              posNext = (upSum > PosMaxX) ? W'(POS_MAX) : upSum[W-1:0];
            else if (expand_in && !compress_in)
              posNext = ({1'b0, pos} < PosMinX + StepX) ? W'(POS_MIN) : pos - StepW;
          end
        end
        MOVE: begin
          if (manualMode) begin
            stateNext = IDLE;
          end else if (pos == target) begin
            stateNext   = HOLD;
            settledNext = 1'b1;
          end else if (tick) begin
            if (target > pos)
              posNext = ((target - pos) > StepW) ? pos + StepW : target;
            else
              posNext = ((pos - target) > StepW) ? pos - StepW : target;
          end
        end
        HOLD: begin
          if (manualMode)         stateNext = IDLE;
          else if (target != pos) stateNext = MOVE;
        end
        default: stateNext = IDLE;
      endcase
    end

    // Direction only follows real movement.
    if (posNext != pos) dirNext = (posNext > pos);
    busyNext = (stateNext == MOVE);
  end

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      state        <= IDLE;
      pos          <= W'(POS_MIN);
      target       <= W'(POS_MIN);
      busy         <= 1'b0;
      settled      <= 1'b0;
      dir_compress <= 1'b0;
    end else begin
      state        <= stateNext;
      pos          <= posNext;
      target       <= targetNext;
      busy         <= busyNext;
      settled      <= settledNext;
      dir_compress <= dirNext;
    end
  end

endmodule

// File: tb/tb_piston_position_ctrl.sv
// Self-checking bench for piston_position_ctrl: default, TICK_DIV=4 and STEP=7 instances.
module tb_piston_position_ctrl;

  logic       clk;
  logic       clear       [3];
  logic       enable      [3];
  logic [1:0] mode        [3];
  logic       compress_in [3];
  logic       expand_in   [3];
  logic [2:0] num_moles   [3];
  logic [2:0] temp        [3];
  logic [7:0] pos         [3];
  logic [7:0] target      [3];
  logic       busy        [3];
  logic       settled     [3];
  logic       dir_compress[3];

  int nvec = 0;
  int nerr = 0;

  typedef struct {
    logic [1:0] mode;
    logic [2:0] n;
    logic [2:0] t;
    int         expTarget;
  } vec_t;

  typedef struct {
    int idx;
    int exp;
  } sb_t;

  vec_t tbl [12];
  sb_t  sbq [$];

  piston_position_ctrl uDef (
    .clk(clk), .clear(clear[0]), .enable(enable[0]), .mode(mode[0]),
    .compress_in(compress_in[0]), .expand_in(expand_in[0]),
    .num_moles(num_moles[0]), .temp(temp[0]),
    .pos(pos[0]), .target(target[0]), .busy(busy[0]),
    .settled(settled[0]), .dir_compress(dir_compress[0])
  );

  piston_position_ctrl #(.TICK_DIV(4)) uDiv (
    .clk(clk), .clear(clear[1]), .enable(enable[1]), .mode(mode[1]),
    .compress_in(compress_in[1]), .expand_in(expand_in[1]),
    .num_moles(num_moles[1]), .temp(temp[1]),
    .pos(pos[1]), .target(target[1]), .busy(busy[1]),
    .settled(settled[1]), .dir_compress(dir_compress[1])
  );

  piston_position_ctrl #(.STEP(7)) uStep (
    .clk(clk), .clear(clear[2]), .enable(enable[2]), .mode(mode[2]),
    .compress_in(compress_in[2]), .expand_in(expand_in[2]),
    .num_moles(num_moles[2]), .temp(temp[2]),
    .pos(pos[2]), .target(target[2]), .busy(busy[2]),
    .settled(settled[2]), .dir_compress(dir_compress[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Advance n clock edges, ending on a falling edge.
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic doClear(input int u);
    clear[u] = 1'b1;
    cyc(1);
    clear[u] = 1'b0;
  endtask

  initial begin
    int edges;
    int hits;
    sb_t s;

    for (int u = 0; u < 3; u++) begin
      clear[u] = 1'b1; enable[u] = 1'b1; mode[u] = 2'd0;
      compress_in[u] = 1'b0; expand_in[u] = 1'b0;
      num_moles[u] = 3'd0; temp[u] = 3'd0;
    end

    tbl[0]  = '{2'd1, 3'd0, 3'd0, 200};
    tbl[1]  = '{2'd1, 3'd1, 3'd0, 161};
    tbl[2]  = '{2'd1, 3'd4, 3'd0, 41};
    tbl[3]  = '{2'd1, 3'd5, 3'd0, 1};
    tbl[4]  = '{2'd1, 3'd6, 3'd0, 1};
    tbl[5]  = '{2'd1, 3'd7, 3'd0, 1};
    tbl[6]  = '{2'd2, 3'd0, 3'd0, 161};
    tbl[7]  = '{2'd2, 3'd0, 3'd1, 121};
    tbl[8]  = '{2'd2, 3'd0, 3'd2, 81};
    tbl[9]  = '{2'd2, 3'd0, 3'd3, 41};
    tbl[10] = '{2'd2, 3'd0, 3'd4, 1};
    tbl[11] = '{2'd2, 3'd0, 3'd7, 1};

    // Reset state
    #1;
    chk("rst_pos", pos[0], 1);
    chk("rst_target", target[0], 1);
    chk("rst_busy", busy[0], 0);
    chk("rst_settled", settled[0], 0);
    chk("rst_dir", dir_compress[0], 0);
    @(negedge clk);
    clear[0] = 1'b0;

    // Target vectors: one cycle latency from inputs to the target register
    for (int i = 0; i < 12; i++) begin
      mode[0] = tbl[i].mode; num_moles[0] = tbl[i].n; temp[0] = tbl[i].t;
      sbq.push_back('{i, tbl[i].expTarget});
      cyc(1);
      s = sbq.pop_front();
      chk($sformatf("target_vec%0d", s.idx), target[0], s.exp);
    end

    // MOLES n=1 from reset: full move, single settle pulse
    mode[0] = 2'd1; num_moles[0] = 3'd1; temp[0] = 3'd0;
    doClear(0);
    cyc(1);
    edges = 1;
    chk("m1_target", target[0], 161);
    chk("m1_busy", busy[0], 1);
    while (!settled[0] && edges < 400) begin
      cyc(1);
      edges++;
    end
    chk("m1_settle_edges", edges, 162);
    chk("m1_settle_pos", pos[0], 161);
    chk("m1_dir", dir_compress[0], 1);
    cyc(1);
    chk("m1_settled_drop", settled[0], 0);
    chk("m1_busy_after", busy[0], 0);
    hits = 0;
    for (int i = 0; i < 10; i++) begin
      cyc(1);
      if (settled[0]) hits++;
    end
    chk("m1_no_repulse", hits, 0);

    // Asynchronous clear mid-move
    doClear(0);
    cyc(20);
    chk("clr_pre_pos", pos[0], 20);
    @(posedge clk);
    #2 clear[0] = 1'b1;
    #1;
    chk("clr_async_pos", pos[0], 1);
    chk("clr_async_busy", busy[0], 0);
    chk("clr_async_target", target[0], 1);
    @(negedge clk);
    clear[0] = 1'b0;

    // enable=0 freezes motion, resume continues
    cyc(10);
    chk("en_pos10", pos[0], 10);
    enable[0] = 1'b0;
    cyc(20);
    chk("en_frozen_pos", pos[0], 10);
    chk("en_frozen_busy", busy[0], 1);
    chk("en_frozen_settled", settled[0], 0);
    enable[0] = 1'b1;
    cyc(5);
    chk("en_resume_pos", pos[0], 15);

    // Mode 3
    mode[0] = 2'd3; num_moles[0] = 3'd2; temp[0] = 3'd3; compress_in[0] = 1'b1;
    doClear(0);
`ifdef GAS_MODE_EN
    cyc(1);
    chk("gas_target", target[0], 141);
    chk("gas_busy", busy[0], 1);
`else
    cyc(10);
    chk("gas_off_pos", pos[0], 1);
    chk("gas_off_target", target[0], 1);
    chk("gas_off_busy", busy[0], 0);
`endif
    compress_in[0] = 1'b0;

    // Manual mode with TICK_DIV=4
    mode[1] = 2'd0; compress_in[1] = 1'b1; expand_in[1] = 1'b0;
    @(negedge clk);
    clear[1] = 1'b0;
    cyc(12);
    chk("man_pos4", pos[1], 4);
    expand_in[1] = 1'b1;
    cyc(8);
    chk("man_both_hold", pos[1], 4);
    expand_in[1] = 1'b0;
    cyc(800);
    chk("man_at_max", pos[1], 200);
    cyc(40);
    chk("man_sat_max", pos[1], 200);
    chk("man_dir_up", dir_compress[1], 1);
    compress_in[1] = 1'b0; expand_in[1] = 1'b1;
    cyc(4);
    chk("man_expand", pos[1], 199);
    chk("man_dir_down", dir_compress[1], 0);
    expand_in[1] = 1'b0;
    cyc(1);
    chk("man_target_follow", target[1], 199);
    chk("man_busy", busy[1], 0);

    // STEP=7, TEMP t=0: last step is 6
    mode[2] = 2'd2; temp[2] = 3'd0;
    @(negedge clk);
    clear[2] = 1'b0;
    edges = 0;
    while (pos[2] != 155 && edges < 100) begin
      cyc(1);
      edges++;
    end
    chk("s7_reach155", pos[2], 155);
    cyc(1);
    chk("s7_last_step", pos[2], 161);
    cyc(1);
    chk("s7_settled", settled[2], 1);
    chk("s7_no_overshoot", pos[2], 161);

    // STEP=7 retarget mid-move reverses direction
    doClear(2);
    cyc(10);
    chk("s7_mid_pos", pos[2], 64);
    temp[2] = 3'd4;
    cyc(1);
    chk("s7_old_target_step", pos[2], 71);
    chk("s7_new_target", target[2], 1);
    cyc(1);
    chk("s7_reverse_pos", pos[2], 64);
    chk("s7_reverse_dir", dir_compress[2], 0);
    edges = 0;
    while (!settled[2] && edges < 100) begin
      cyc(1);
      edges++;
    end
    chk("s7_return_settled", settled[2], 1);
    chk("s7_return_pos", pos[2], 1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
